// File: rtl/ubtb_update_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ubtb_update_ctrl
// Brief    : Serializes redirect/commit uBTB training through a coalescing
//            FIFO and sequences the full-table invalidate walk on flush.
// Revision : 1.0
// ============================================================================
module ubtb_update_ctrl #(
    parameter int DEPTH     = 4,
    parameter int DATA_W    = 128,
    parameter int TAG_W     = 8,
    parameter int UBTB_SIZE = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rd_valid_i,
    output logic                         rd_ready_o,
    input  logic [TAG_W-1:0]             rd_tag_i,
    input  logic [DATA_W-1:0]            rd_data_i,
    input  logic                         cm_valid_i,
    output logic                         cm_ready_o,
    input  logic [TAG_W-1:0]             cm_tag_i,
    input  logic [DATA_W-1:0]            cm_data_i,
    output logic                         upd_valid_o,
    input  logic                         upd_ready_i,
    output logic [TAG_W-1:0]             upd_tag_o,
    output logic [DATA_W-1:0]            upd_data_o,
    input  logic                         flush_req_i,
    output logic                         inv_valid_o,
    output logic [$clog2(UBTB_SIZE)-1:0] inv_idx_o,
    output logic                         flush_busy_o,
    output logic                         flush_done_o,
    output logic [$clog2(DEPTH):0]       count_o
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;
    localparam int WW = $clog2(UBTB_SIZE);
    localparam logic [WW-1:0] C_LAST_IDX = WW'(UBTB_SIZE - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_FLUSH = 1'b1
    } state_e;

    state_e            state_q;
    logic [PW-1:0]     wptr_q;
    logic [PW-1:0]     rptr_q;
    logic [WW-1:0]     walk_q;
    logic              done_q;
    logic [TAG_W-1:0]  tag_q  [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];

    logic              w_idle;
    logic              w_empty;
    logic              w_full;
    logic              w_deq;
    logic              w_enq;
    logic              w_sel_rd;
    logic              w_coalesce;
    logic              w_push;
    logic [PW-1:0]     w_count;
    logic [PW-1:0]     w_young_ptr;
    logic [IW-1:0]     w_young_idx;
    logic [IW-1:0]     w_head_idx;
    logic [IW-1:0]     w_wr_idx;
    logic [TAG_W-1:0]  w_in_tag;
    logic [DATA_W-1:0] w_in_data;

    assign w_idle      = (state_q == S_IDLE);
    assign w_count     = wptr_q - rptr_q;
    assign w_empty     = (wptr_q == rptr_q);
    assign w_full      = (wptr_q[IW-1:0] == rptr_q[IW-1:0]) && (wptr_q[IW] != rptr_q[IW]);
    assign w_head_idx  = rptr_q[IW-1:0];
    assign w_young_ptr = wptr_q - PW'(1);
    assign w_young_idx = w_young_ptr[IW-1:0];

    // Redirect wins; commit only gets the slot when redirect is idle.
    assign rd_ready_o  = ~w_full & w_idle & ~flush_req_i;
    assign cm_ready_o  = rd_ready_o & ~rd_valid_i;

    assign upd_valid_o = w_idle & ~w_empty;
    assign upd_tag_o   = tag_q[w_head_idx];
    assign upd_data_o  = data_q[w_head_idx];

    assign w_deq       = upd_valid_o & upd_ready_i;
    assign w_sel_rd    = rd_valid_i & rd_ready_o;
    assign w_enq       = w_sel_rd | (cm_valid_i & cm_ready_o);
    assign w_in_tag    = w_sel_rd ? rd_tag_i  : cm_tag_i;
    assign w_in_data   = w_sel_rd ? rd_data_i : cm_data_i;

    // A lone entry leaving this cycle cannot absorb the newcomer.
    assign w_coalesce  = w_enq & ~w_empty & (tag_q[w_young_idx] == w_in_tag)
                         & ~(w_deq & (w_count == PW'(1)));
    assign w_push      = w_enq & ~w_coalesce;
    assign w_wr_idx    = w_coalesce ? w_young_idx : wptr_q[IW-1:0];

    assign count_o      = w_count;
    assign inv_valid_o  = (state_q == S_FLUSH);
    assign flush_busy_o = (state_q == S_FLUSH);
    assign inv_idx_o    = walk_q;
    assign flush_done_o = done_q;

    always_ff @(posedge clk) begin
        if (w_push | w_coalesce) begin
            tag_q[w_wr_idx]  <= w_in_tag;
            data_q[w_wr_idx] <= w_in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            wptr_q  <= '0;
            rptr_q  <= '0;
            walk_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (flush_req_i) begin
                        state_q <= S_FLUSH;
                        walk_q  <= '0;
                        wptr_q  <= '0;
                        rptr_q  <= '0;
                    end else begin
                        if (w_push) wptr_q <= wptr_q + PW'(1);
                        if (w_deq)  rptr_q <= rptr_q + PW'(1);
                    end
                end
                S_FLUSH: begin
                    if (flush_req_i) begin
                        walk_q <= '0;
                    end else if (walk_q == C_LAST_IDX) begin
                        state_q <= S_IDLE;
                        walk_q  <= '0;
                        done_q  <= 1'b1;
                    end else begin
                        walk_q <= walk_q + WW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ubtb_update_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ubtb_update_ctrl
// Brief    : Directed bench with an update scoreboard for ubtb_update_ctrl.
// Revision : 1.0
// ============================================================================
module tb_ubtb_update_ctrl;

    localparam int DEPTH     = 4;
    localparam int DATA_W    = 128;
    localparam int TAG_W     = 8;
    localparam int UBTB_SIZE = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              rd_valid, rd_ready, cm_valid, cm_ready;
    logic [TAG_W-1:0]  rd_tag, cm_tag, upd_tag;
    logic [DATA_W-1:0] rd_data, cm_data, upd_data;
    logic              upd_valid, upd_ready;
    logic              flush_req, inv_valid, flush_busy, flush_done;
    logic [3:0]        inv_idx;
    logic [2:0]        count;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } upd_t;

    upd_t exp_q[$];
    upd_t mon_e;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ubtb_update_ctrl #(
        .DEPTH(DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W), .UBTB_SIZE(UBTB_SIZE)
    ) dut (
        .clk(clk), .rst(rst),
        .rd_valid_i(rd_valid), .rd_ready_o(rd_ready), .rd_tag_i(rd_tag), .rd_data_i(rd_data),
        .cm_valid_i(cm_valid), .cm_ready_o(cm_ready), .cm_tag_i(cm_tag), .cm_data_i(cm_data),
        .upd_valid_o(upd_valid), .upd_ready_i(upd_ready), .upd_tag_o(upd_tag), .upd_data_o(upd_data),
        .flush_req_i(flush_req), .inv_valid_o(inv_valid), .inv_idx_o(inv_idx),
        .flush_busy_o(flush_busy), .flush_done_o(flush_done), .count_o(count)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] mk(input int n);
        logic [15:0] lo;
        lo = n[15:0];
        return {4{16'hA5A5, lo}};
    endfunction

    task automatic expect_upd(input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
        upd_t e;
        e.tag  = t;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every accepted update must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst) begin
            chk("inv_upd_exclusive", inv_valid & upd_valid, 0);
            if (upd_valid && upd_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL upd_unexpected: got tag %0h expected none", upd_tag);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("upd_tag", upd_tag, mon_e.tag);
                    chk("upd_data", upd_data, mon_e.data);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        logic [TAG_W-1:0] t2 [3];
        t2 = '{8'h01, 8'h11, 8'h21};

        rst = 1'b1; rd_valid = 0; cm_valid = 0; flush_req = 0; upd_ready = 0;
        rd_tag = '0; cm_tag = '0; rd_data = '0; cm_data = '0;
        step(); step();
        @(negedge clk);
        chk("rst_upd_valid", upd_valid, 0);
        chk("rst_inv_valid", inv_valid, 0);
        chk("rst_inv_idx", inv_idx, 0);
        chk("rst_flush_busy", flush_busy, 0);
        chk("rst_flush_done", flush_done, 0);
        chk("rst_count", count, 0);
        chk("rst_rd_ready", rd_ready, 1);
        chk("rst_cm_ready", cm_ready, 1);
        step();
        rst = 1'b0;

        // Single commit request
        upd_ready = 1; cm_valid = 1; cm_tag = 8'h12; cm_data = mk(1);
        expect_upd(8'h12, mk(1));
        @(negedge clk);
        chk("t1_cm_ready", cm_ready, 1);
        step();
        cm_valid = 0;
        @(negedge clk);
        chk("t1_upd_valid", upd_valid, 1);
        chk("t1_count", count, 1);
        step();
        @(negedge clk);
        chk("t1_count_drained", count, 0);
        chk("t1_upd_valid_low", upd_valid, 0);
        step();

        // Redirect priority over commit
        upd_ready = 0;
        for (int i = 0; i < 3; i++) begin
            rd_valid = 1; rd_tag = t2[i]; rd_data = mk(16 + i);
            cm_valid = 1; cm_tag = 8'h02; cm_data = mk(99);
            expect_upd(t2[i], mk(16 + i));
            @(negedge clk);
            chk("t2_rd_ready", rd_ready, 1);
            chk("t2_cm_ready", cm_ready, 0);
            step();
        end
        rd_valid = 0; cm_valid = 0;
        @(negedge clk);
        chk("t2_count", count, 3);
        chk("t2_head_tag", upd_tag, 8'h01);
        step();
        upd_ready = 1;
        repeat (3) step();
        @(negedge clk);
        chk("t2_count_drained", count, 0);
        step();

        // Fill to DEPTH, hold off the fifth, free one slot
        upd_ready = 0;
        for (int i = 0; i < 4; i++) begin
            cm_valid = 1; cm_tag = 8'h40 + 8'(i); cm_data = mk(64 + i);
            expect_upd(8'h40 + 8'(i), mk(64 + i));
            step();
        end
        cm_tag = 8'h44; cm_data = mk(68);
        @(negedge clk);
        chk("t3_count_full", count, 4);
        chk("t3_rd_ready_full", rd_ready, 0);
        chk("t3_cm_ready_full", cm_ready, 0);
        step();
        upd_ready = 1;
        @(negedge clk);
        chk("t3_no_bypass", cm_ready, 0);
        chk("t3_count_still4", count, 4);
        step();
        upd_ready = 0;
        expect_upd(8'h44, mk(68));
        @(negedge clk);
        chk("t3_ready_back", cm_ready, 1);
        chk("t3_count3", count, 3);
        step();
        cm_valid = 0;
        @(negedge clk);
        chk("t3_count_refill", count, 4);
        step();
        upd_ready = 1;
        repeat (4) step();
        @(negedge clk);
        chk("t3_count_drained", count, 0);
        step();

        // Coalescing into the youngest entry
        upd_ready = 0;
        cm_valid = 1; cm_tag = 8'h33; cm_data = mk(10);
        step();
        cm_data = mk(11);
        expect_upd(8'h33, mk(11));
        step();
        cm_valid = 0;
        @(negedge clk);
        chk("t4_coalesce_count", count, 1);
        chk("t4_coalesce_data", upd_data, mk(11));
        step();
        upd_ready = 1;
        step();
        upd_ready = 0;
        @(negedge clk);
        chk("t4_count_drained", count, 0);
        step();
        cm_valid = 1; cm_tag = 8'h33; cm_data = mk(12);
        expect_upd(8'h33, mk(12));
        step();
        cm_data = mk(13); upd_ready = 1;
        expect_upd(8'h33, mk(13));
        @(negedge clk);
        chk("t4_head_deq_ready", cm_ready, 1);
        step();
        cm_valid = 0;
        @(negedge clk);
        chk("t4_no_coalesce_count", count, 1);
        step();
        upd_ready = 0;
        @(negedge clk);
        chk("t4_count_final", count, 0);
        step();

        // Flush walk with queued entries
        cm_valid = 1; cm_tag = 8'h50; cm_data = mk(80);
        step();
        cm_tag = 8'h51; cm_data = mk(81);
        step();
        cm_valid = 0;
        @(negedge clk);
        chk("t5_count_pre", count, 2);
        step();
        flush_req = 1; cm_valid = 1; cm_tag = 8'h60; cm_data = mk(96);
        @(negedge clk);
        chk("t5_flush_cycle_cm_ready", cm_ready, 0);
        chk("t5_flush_cycle_rd_ready", rd_ready, 0);
        step();
        flush_req = 0; cm_valid = 0; upd_ready = 1;
        for (int i = 0; i < UBTB_SIZE; i++) begin
            @(negedge clk);
            chk("t5_inv_valid", inv_valid, 1);
            chk("t5_inv_idx", inv_idx, i);
            chk("t5_flush_busy", flush_busy, 1);
            chk("t5_upd_valid", upd_valid, 0);
            chk("t5_rd_ready", rd_ready, 0);
            chk("t5_count", count, 0);
            step();
        end
        @(negedge clk);
        chk("t5_flush_done", flush_done, 1);
        chk("t5_inv_valid_end", inv_valid, 0);
        chk("t5_flush_busy_end", flush_busy, 0);
        chk("t5_rd_ready_end", rd_ready, 1);
        chk("t5_count_end", count, 0);
        step();
        @(negedge clk);
        chk("t5_flush_done_pulse", flush_done, 0);
        step();

        // Restart mid-walk, then reset mid-walk
        upd_ready = 0; flush_req = 1;
        step();
        flush_req = 0;
        repeat (3) step();
        flush_req = 1;
        @(negedge clk);
        chk("t6_idx3", inv_idx, 3);
        step();
        flush_req = 0;
        @(negedge clk);
        chk("t6_restart_idx", inv_idx, 0);
        chk("t6_restart_busy", flush_busy, 1);
        repeat (7) step();
        rst = 1;
        @(negedge clk);
        chk("t6_idx7", inv_idx, 7);
        step();
        rst = 0;
        @(negedge clk);
        chk("t6_rst_busy", flush_busy, 0);
        chk("t6_rst_inv_valid", inv_valid, 0);
        chk("t6_rst_count", count, 0);
        chk("t6_rst_rd_ready", rd_ready, 1);
        chk("t6_rst_flush_done", flush_done, 0);
        step();

        // Reset with a non-empty FIFO
        cm_valid = 1; cm_tag = 8'h70; cm_data = mk(112);
        step();
        cm_tag = 8'h71; cm_data = mk(113);
        step();
        cm_valid = 0; rst = 1;
        @(negedge clk);
        chk("t7_count_pre", count, 2);
        step();
        rst = 0;
        @(negedge clk);
        chk("t7_rst_count", count, 0);
        chk("t7_rst_upd_valid", upd_valid, 0);
        step();

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ubtb_update_ctrl.md
# ubtb_update_ctrl

Schedules micro-BTB write traffic. Arbitrates between two update requesters (redirect-time training and commit-time training) through a small coalescing FIFO, and issues at most one update per cycle to the uBTB write port. Also sequences a full-table invalidate walk on a flush command. Sits between the BPU update path and the uBTB, so the uBTB sees a single serialized update stream.

## Interface
- DEPTH, 4, update FIFO entries (power of two, ≥2)
- DATA_W, 128, opaque update payload width (BTB entry + meta + realTaken + allocSlot)
- TAG_W, 8, uBTB tag width used for coalescing
- UBTB_SIZE, 16, uBTB entries swept by a flush (power of two)

Ports:
- clk  in  1  clock; single clock domain
- rst  in  1  reset; synchronous, active-high
- rd_valid  in  1  redirect-time update request
- rd_ready  out  1  redirect request accepted this cycle
- rd_tag  in  TAG_W  tag of start_addr of the redirect request
- rd_data  in  DATA_W  redirect payload
- cm_valid  in  1  commit-time update request
- cm_ready  out  1  commit request accepted this cycle
- cm_tag  in  TAG_W  tag of commit request
- cm_data  in  DATA_W  commit payload
- upd_valid  out  1  update presented to uBTB
- upd_ready  in  1  uBTB takes the update this cycle
- upd_tag  out  TAG_W  tag of presented update
- upd_data  out  DATA_W  payload of presented update
- flush_req  in  1  one-cycle pulse; start invalidate walk
- inv_valid  out  1  invalidate entry inv_idx this cycle
- inv_idx  out  $clog2(UBTB_SIZE)  entry index to invalidate
- flush_busy  out  1  walk in progress
- flush_done  out  1  one-cycle pulse after last invalidate
- count  out  $clog2(DEPTH)+1  FIFO occupancy

## Operation
- FSM states: IDLE, FLUSH. Reset → IDLE.
- IDLE: accepts requests; FIFO head drives upd_*; upd_valid = (count != 0).
- Arbitration: redirect has fixed priority. rd_ready = ~full & IDLE & ~flush_req. cm_ready = rd_ready & ~rd_valid. At most one enqueue per cycle.
- Full means count == DEPTH, evaluated before this cycle's dequeue; there is no enqueue/dequeue bypass when full.
- Coalescing: if an accepted request's tag equals the tag of the youngest FIFO entry, and that entry is not the head being dequeued this cycle (upd_valid & upd_ready), then its data and tag are overwritten in place. count is unchanged. Otherwise the request is pushed at tail. Coalescing is still refused when full (ready is already low).
- Dequeue: head pops when upd_valid & upd_ready. Enqueue and dequeue in the same cycle leave count unchanged.
- Pointers are $clog2(DEPTH)+1 bits with a wrap bit. Full = index bits equal and wrap bits differ. Empty = pointers equal.
- flush_req in IDLE:
  - Discard all FIFO contents next cycle (pointers and count to 0).
  - Enter FLUSH with walk counter 0.
  - A request presented in the flush_req cycle is not accepted.
- FLUSH:
  - inv_valid = 1 and inv_idx = walk counter.
  - Counter increments every cycle; invalidates are unconditional, with no ready.
  - After index UBTB_SIZE-1 is issued, go to IDLE and pulse flush_done in the first IDLE cycle.
  - upd_valid = 0, rd_ready = cm_ready = 0, flush_busy = 1 throughout.
- flush_req during FLUSH restarts the walk at index 0.
- The uBTB must apply invalidate before update if both ever coincide. By construction this block never asserts inv_valid and upd_valid together.

## Timing
- Reset values:
  - upd_valid=0, inv_valid=0, inv_idx=0
  - flush_busy=0, flush_done=0, count=0
  - rd_ready=cm_ready=1 if not full, i.e. 1
  - FIFO pointers 0
- Request latency: accepted at edge N, visible on upd_* at N+1 at the earliest (registered FIFO, no bypass).
- Throughput: one update per cycle sustained with upd_ready held high.
- Flush: flush_req at edge N.
  - FLUSH occupies cycles N+1 … N+UBTB_SIZE with inv_idx 0 … UBTB_SIZE-1.
  - flush_done is high in cycle N+UBTB_SIZE+1.
  - Requests are accepted again from cycle N+UBTB_SIZE+1.
- Reset mid-flush or with a non-empty FIFO: the next cycle is IDLE, empty, all outputs at reset values.
- upd_data and upd_tag are stable while upd_valid & ~upd_ready.

## Test plan
- Single commit request, tag 0x12, upd_ready=1: accepted cycle 0 → upd_valid cycle 1 with tag 0x12 → count returns to 0 cycle 2.
- rd_valid and cm_valid together for 3 cycles (tags 0x01/0x02): rd_ready=1, cm_ready=0 each cycle → FIFO holds 3 redirect entries in order.
- upd_ready=0, enqueue 4 distinct tags: count=4, rd_ready=0 → 5th held off → one upd_ready pulse pops the first tag, ready returns next cycle.
- upd_ready=0, enqueue tag 0x33 data A then tag 0x33 data B: count stays 1 → head shows data B. Repeat with 0x33 as head being dequeued: second push creates a new entry.
- Two entries queued, flush_req pulse (UBTB_SIZE=16): count=0 next cycle, inv_idx 0…15 over 16 cycles, flush_done one cycle after, upd_valid never high during walk.
- rst asserted at walk index 7: next cycle flush_busy=0, inv_valid=0, count=0, rd_ready=1.
